riscv_wb_stage: RTL



---
 rtl/riscv_wb_stage_pkg.sv | 22 ++
 rtl/riscv_wb_stage_ld_fmt.sv | 55 +++++
 rtl/riscv_wb_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/riscv_wb_stage_pkg.sv
// Shared write-back definitions: data/index widths, load funct3 encodings
// and the retired-instruction counter width.
package riscv_wb_stage_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned INSTRET_W  = 64;
  localparam int unsigned FUNCT3_W   = 3;

  localparam logic [FUNCT3_W-1:0] LD_LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] LD_LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] LD_LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] LD_LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] LD_LHU = 3'b101;

  // True for the five legal load encodings; anything else is a format error.
  function automatic logic ld_funct3_legal(input logic [FUNCT3_W-1:0] f3);
    return (f3 == LD_LB) || (f3 == LD_LH) || (f3 == LD_LW) ||
           (f3 == LD_LBU) || (f3 == LD_LHU);
  endfunction

endpackage

// File: rtl/riscv_wb_stage_ld_fmt.sv
// Combinational load extractor: picks the byte/half/word out of an aligned
// memory word, extends it, and flags misalignment or an illegal funct3.
module riscv_ld_fmt
  import riscv_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [XLEN-1:0]     rdata_i,
  output logic [XLEN-1:0]     value_o,
  output logic                err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
  end

  // Misaligned or illegal loads return zero so nothing stale reaches rd.
  always_comb begin
    value_o = '0;
    err_o   = 1'b0;
    case (funct3_i)
      LD_LB:  value_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LBU: value_o = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LH: begin
        if (addr_lo_i[0]) begin
          err_o = 1'b1;
        end else begin
          value_o = {{(XLEN-16){half_sel[15]}}, half_sel};
        end
      end
      LD_LHU: begin
        if (addr_lo_i[0]) begin
          err_o = 1'b1;
        end else begin
          value_o = {{(XLEN-16){1'b0}}, half_sel};
        end
      end
      LD_LW: begin
        if (addr_lo_i != 2'b00) begin
          err_o = 1'b1;
        end else begin
          value_o = rdata_i;
        end
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// Write-back stage: one-entry output register between the memory stage and
// the register file; drives the rf write port, commit pulse and instret.
module riscv_wb_stage
  import riscv_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [REG_AW-1:0]    in_rd_idx,
  input  logic                 in_rd_we,
  input  logic                 in_is_load,
  input  logic [FUNCT3_W-1:0]  in_ld_funct3,
  input  logic [1:0]           in_ld_addr_lo,
  input  logic [XLEN-1:0]      in_alu_res,
  input  logic [XLEN-1:0]      in_mem_rdata,
  input  logic                 hold_i,
  output logic [REG_AW-1:0]    rd_idx_o,
  output logic                 rd_we_o,
  output logic [XLEN-1:0]      rd_val_o,
  output logic                 commit_valid_o,
  output logic [XLEN-1:0]      commit_pc_o,
  output logic                 ld_err_o,
  output logic [INSTRET_W-1:0] instret_o
);

  logic                 wb_valid_q,  wb_valid_d;
  logic [XLEN-1:0]      wb_pc_q,     wb_pc_d;
  logic [REG_AW-1:0]    wb_rd_idx_q, wb_rd_idx_d;
  logic                 wb_rd_we_q,  wb_rd_we_d;
  logic [XLEN-1:0]      wb_val_q,    wb_val_d;
  logic                 wb_err_q,    wb_err_d;
  logic [INSTRET_W-1:0] instret_q,   instret_d;

  logic            retire_c;
  logic            accept_c;
  logic [XLEN-1:0] fmt_val_c;
  logic            fmt_err_c;
  logic [XLEN-1:0] in_val_c;
  logic            in_err_c;

  riscv_ld_fmt #(
    .XLEN (XLEN)
  ) u_ld_fmt (
    .funct3_i  (in_ld_funct3),
    .addr_lo_i (in_ld_addr_lo),
    .rdata_i   (in_mem_rdata),
    .value_o   (fmt_val_c),
    .err_o     (fmt_err_c)
  );

  // Handshake: the entry drains unless frozen, and a retiring slot refills with no bubble.
  always_comb begin
    retire_c = wb_valid_q & ~hold_i;
    in_ready = ~wb_valid_q | retire_c;
    accept_c = in_valid & in_ready;
    in_val_c = in_is_load ? fmt_val_c : in_alu_res;
    in_err_c = in_is_load & fmt_err_c;
  end

  always_comb begin
    wb_valid_d  = wb_valid_q;
    wb_pc_d     = wb_pc_q;
    wb_rd_idx_d = wb_rd_idx_q;
    wb_rd_we_d  = wb_rd_we_q;
    wb_val_d    = wb_val_q;
    wb_err_d    = wb_err_q;
    instret_d   = instret_q + INSTRET_W'(retire_c);
    if (accept_c) begin
      wb_valid_d  = 1'b1;
      wb_pc_d     = in_pc;
      wb_rd_idx_d = in_rd_idx;
      wb_rd_we_d  = in_rd_we;
      wb_val_d    = in_val_c;
      wb_err_d    = in_err_c;
    end else if (retire_c) begin
      wb_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_rd_idx_q <= '0;
      wb_rd_we_q  <= 1'b0;
      wb_val_q    <= '0;
      wb_err_q    <= 1'b0;
      instret_q   <= '0;
    end else begin
      wb_valid_q  <= wb_valid_d;
      wb_pc_q     <= wb_pc_d;
      wb_rd_idx_q <= wb_rd_idx_d;
      wb_rd_we_q  <= wb_rd_we_d;
      wb_val_q    <= wb_val_d;
      wb_err_q    <= wb_err_d;
      instret_q   <= instret_d;
    end
  end

  // Pulses follow the retire condition so a falling hold_i retires in that same cycle.
  always_comb begin
    rd_idx_o       = wb_rd_idx_q;
    rd_val_o       = wb_val_q;
    rd_we_o        = retire_c & wb_rd_we_q & (wb_rd_idx_q != '0);
    commit_valid_o = retire_c;
    commit_pc_o    = wb_pc_q;
    ld_err_o       = retire_c & wb_err_q;
    instret_o      = instret_q;
  end

endmodule
